// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED pattern sequencer.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_ROT_R  = 2'd2,
    MODE_BAR    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_WAIT_W = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DELAY  = 3'd4
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;

endpackage

// File: rtl/led_sequencer_button_toggle.sv
// Button synchroniser, rising-edge detector and run/pause toggle.
module button_toggle (
  input  logic clk,
  input  logic resetn,
  input  logic button,
  output logic running
);

  logic sync1;
  logic sync2;
  logic sync3;
  logic rise;

  assign rise = sync2 & ~sync3;

  // Two-flop synchroniser, delayed copy for edge detect, and toggle flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      running <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      sync3 <= sync2;
      if (rise) running <= ~running;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer driving an AXI4-Lite LED register, one write in flight.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned FREQ_HZ    = 100000000,
  parameter logic [31:0] SLAVE_ADDR = 32'h1000,
  parameter int unsigned NUM_LEDS   = 16,
  parameter int unsigned EYE_WIDTH  = 3,
  parameter int unsigned DELAY_BITS = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  button,
  input  logic [1:0]            mode,
  input  logic [DELAY_BITS-1:0] ms_delay,
  output logic                  running,
  output logic [NUM_LEDS-1:0]   pattern_out,
  output logic [7:0]            err_count,
  output logic [31:0]           M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [31:0]           M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int unsigned CPM   = (FREQ_HZ / 1000 < 1) ? 1 : FREQ_HZ / 1000;
  localparam int unsigned DIV_W = $clog2(CPM + 1);
  localparam logic [DIV_W-1:0]    DIV_LOAD = DIV_W'(CPM - 1);
  localparam logic [NUM_LEDS-1:0] EYE_MASK =
    {{(NUM_LEDS - EYE_WIDTH){1'b0}}, {EYE_WIDTH{1'b1}}};

  state_e                state;
  dir_e                  dir;
  mode_e                 mode_in;
  logic [1:0]            last_mode;
  logic                  init_wr;
  logic [NUM_LEDS-1:0]   pattern;
  logic [DELAY_BITS-1:0] ms_cnt;
  logic [DIV_W-1:0]      div_cnt;

  logic unused_rd;
  assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};

  assign mode_in       = mode_e'(mode);
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  function automatic logic [NUM_LEDS-1:0] start_pat(input mode_e m);
    return (m == MODE_BAR) ? '0 : EYE_MASK;
  endfunction

  button_toggle u_button (
    .clk     (clk),
    .resetn  (resetn),
    .button  (button),
    .running (running)
  );

  // Sequencer FSM with the AXI write handshake folded in; the INIT write
  // returns straight to IDLE so the start pattern is the first one shown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_INIT;
      dir           <= DIR_LEFT;
      last_mode     <= '0;
      init_wr       <= 1'b0;
      pattern       <= '0;
      ms_cnt        <= '0;
      div_cnt       <= '0;
      pattern_out   <= '0;
      err_count     <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
      if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
      case (state)
        ST_INIT: begin
          M_AXI_AWADDR  <= SLAVE_ADDR;
          M_AXI_AWVALID <= 1'b1;
          M_AXI_WDATA   <= '0;
          M_AXI_WSTRB   <= AXI_WSTRB_ALL;
          M_AXI_WVALID  <= 1'b1;
          M_AXI_BREADY  <= 1'b1;
          pattern       <= start_pat(mode_in);
          last_mode     <= mode;
          dir           <= DIR_LEFT;
          init_wr       <= 1'b1;
          state         <= ST_WAIT_W;
        end
        ST_IDLE: begin
          if (running) begin
            M_AXI_AWADDR  <= SLAVE_ADDR;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WDATA   <= 32'(pattern);
            M_AXI_WSTRB   <= AXI_WSTRB_ALL;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_BREADY  <= 1'b1;
            state         <= ST_WAIT_W;
          end
        end
        ST_WAIT_W: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            pattern_out  <= M_AXI_WDATA[NUM_LEDS-1:0];
            if (M_AXI_BRESP != AXI_RESP_OKAY && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            if (init_wr) begin
              init_wr <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state   <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (mode != last_mode) begin
            pattern   <= start_pat(mode_in);
            dir       <= DIR_LEFT;
            last_mode <= mode;
          end else begin
            case (mode_in)
              MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                  pattern <= pattern << 1;
                  if (pattern[NUM_LEDS-2]) dir <= DIR_RIGHT;
                end else begin
                  pattern <= pattern >> 1;
                  if (pattern[1]) dir <= DIR_LEFT;
                end
              end
              MODE_ROT_L: pattern <= {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
              MODE_ROT_R: pattern <= {pattern[0], pattern[NUM_LEDS-1:1]};
              MODE_BAR:   pattern <= (&pattern) ? '0 : {pattern[NUM_LEDS-2:0], 1'b1};
              default:    pattern <= pattern;
            endcase
          end
          ms_cnt  <= ms_delay;
          div_cnt <= DIV_LOAD;
          state   <= ST_DELAY;
        end
        ST_DELAY: begin
          if (ms_cnt == '0) begin
            state <= ST_IDLE;
          end else if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
            ms_cnt  <= ms_cnt - 1'b1;
            if (ms_cnt == DELAY_BITS'(1)) state <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
